// File: rtl/chebyshev_recurrence.sv
// rtl/chebyshev_recurrence.sv - Chebyshev T_0..T_N(x) generator using T_k = 2x*T_{k-1} - T_{k-2}
// Results wrap in EXT = WL+G bits with a sticky overflow flag; clamping happens downstream.
module chebyshev_recurrence #(
    parameter int WL    = 16,
    parameter int FRAC  = 12,
    parameter int G     = 4,
    parameter int ORD_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WL-1:0]       in_x,
    input  logic [ORD_W-1:0]    in_order,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WL+G-1:0]     out_data,
    output logic [ORD_W-1:0]    out_index,
    output logic                out_last,
    output logic                out_ovf
);

    localparam int EXT = WL + G;
    localparam logic [EXT-1:0] ONE = {{(EXT-1){1'b0}}, 1'b1} << FRAC;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_CALC} state_t;

    state_t             r_state;
    logic [WL-1:0]      r_x;
    logic [ORD_W-1:0]   r_ord;
    logic [EXT-1:0]     r_tcur;
    logic [EXT-1:0]     r_tprev;
    logic [ORD_W-1:0]   r_idx;
    logic               r_ovf;
    logic               r_in_ready;

    logic signed [WL+EXT-1:0] w_p;
    logic signed [WL+EXT-1:0] w_s;
    logic signed [EXT:0]      w_d;
    logic                     w_s_fit;
    logic                     w_d_fit;

    // Shifting by FRAC-1 instead of FRAC folds the factor of two into the rescale.
    assign w_p     = $signed(r_x) * $signed(r_tcur);
    assign w_s     = w_p >>> (FRAC - 1);
    assign w_d     = $signed(w_s[EXT:0]) - $signed({r_tprev[EXT-1], r_tprev});
    assign w_s_fit = (w_s[WL+EXT-1:EXT-1] == '0) || (w_s[WL+EXT-1:EXT-1] == '1);
    assign w_d_fit = (w_d[EXT] == w_d[EXT-1]);

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == S_EMIT);
    assign out_data  = r_tcur;
    assign out_index = r_idx;
    assign out_last  = (r_state == S_EMIT) && (r_idx == r_ord);
    assign out_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_ord      <= '0;
            r_tcur     <= '0;
            r_tprev    <= '0;
            r_idx      <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x        <= in_x;
                        r_ord      <= in_order;
                        r_tcur     <= ONE;
                        r_tprev    <= '0;
                        r_idx      <= '0;
                        r_ovf      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EMIT;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (r_idx == r_ord) begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (r_idx == '0) begin
                            r_tprev <= r_tcur;
                            r_tcur  <= {{G{r_x[WL-1]}}, r_x};
                            r_idx   <= r_idx + 1'b1;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_tcur  <= w_d[EXT-1:0];
                    r_tprev <= r_tcur;
                    r_idx   <= r_idx + 1'b1;
                    r_ovf   <= r_ovf | ~w_s_fit | ~w_d_fit;
                    r_state <= S_EMIT;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chebyshev_recurrence.sv
// tb/tb_chebyshev_recurrence.sv - scoreboard bench for chebyshev_recurrence
// Directed requests push expected samples; a negedge monitor pops and compares on each handshake.
module tb_chebyshev_recurrence;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [3:0]  in_order = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        out_ovf;

    chebyshev_recurrence dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_order(in_order), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] d;
        logic [3:0]  k;
        logic        l;
        logic        o;
        int          t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   bp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int d, input int k, input bit l, input bit o, input int t);
        exp_t e;
        e.d = 20'(d);
        e.k = 4'(k);
        e.l = l;
        e.o = o;
        e.t = t;
        q.push_back(e);
    endtask

    always begin
        @(posedge clk);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor state
    bit          stall_prev = 1'b0;
    bit          last_prev = 1'b0;
    logic [19:0] sd;
    logic [3:0]  sk;
    logic        sl;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                chk("stall_data", out_data, sd);
                chk("stall_index", out_index, sk);
                chk("stall_last", out_last, sl);
            end
            if (last_prev) chk("ready_after_last", in_ready, 1);
            last_prev = 1'b0;
            if (out_valid) chk("ready_low_busy", in_ready, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", out_data, e.d);
                    chk("index", out_index, e.k);
                    chk("last", out_last, e.l);
                    chk("ovf", out_ovf, e.o);
                    if (e.t >= 0) chk("valid_cycle", cyc - acc_cyc + 1, e.t);
                end
                last_prev = out_last;
            end
            stall_prev = out_valid && !out_ready;
            sd = out_data;
            sk = out_index;
            sl = out_last;
        end
    end

    task automatic send(input logic [15:0] x, input logic [3:0] n);
        int waits = 0;
        @(posedge clk);
        #1;
        in_x = x;
        in_order = n;
        in_valid = 1'b1;
        while (!in_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        in_x = 16'($urandom);
        in_order = 4'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_ovf", out_ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1);

        // Basic sequence with timing, x = 0.5
        push(4096, 0, 0, 0, 1);
        push(2048, 1, 0, 0, 2);
        push(-2048, 2, 0, 0, 4);
        push(-4096, 3, 0, 0, 6);
        push(-2048, 4, 1, 0, 8);
        send(16'd2048, 4'd4);
        wait_done();

        // x = 1.0
        for (int k = 0; k <= 5; k++) push(4096, k, k == 5, 0, -1);
        send(16'd4096, 4'd5);
        wait_done();

        // x = -1.0
        for (int k = 0; k <= 3; k++) push((k % 2) ? -4096 : 4096, k, k == 3, 0, -1);
        send(16'hF000, 4'd3);
        wait_done();

        // Overflow, x = 7.0; T3 = 5533696 wraps to 290816
        push(4096, 0, 0, 0, -1);
        push(28672, 1, 0, 0, -1);
        push(397312, 2, 0, 0, -1);
        push(290816, 3, 1, 1, -1);
        send(16'd28672, 4'd3);
        wait_done();
        push(4096, 0, 0, 0, -1);
        push(4096, 1, 1, 0, -1);
        send(16'd4096, 4'd1);
        wait_done();

        // Backpressure, in_x scrambled by send after acceptance
        bp_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(4096, 0, 0, 0, -1);
            push(2048, 1, 0, 0, -1);
            push(-2048, 2, 0, 0, -1);
            push(-4096, 3, 1, 0, -1);
            send(16'd2048, 4'd3);
            wait_done();
        end
        bp_en = 1'b0;
        @(posedge clk);

        // Back-to-back with in_valid held high
        for (int r = 0; r < 3; r++) begin
            push(4096, 0, 0, 0, -1);
            push(2048, 1, 1, 0, -1);
        end
        @(posedge clk);
        #1;
        in_x = 16'd2048;
        in_order = 4'd1;
        in_valid = 1'b1;
        begin
            int n = 0;
            while (q.size() != 0 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_drained", q.size(), 0);
        wait_done();

        // Reset during the T2 CALC cycle
        push(4096, 0, 0, 0, -1);
        push(2048, 1, 0, 0, -1);
        send(16'd2048, 4'd4);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_index", out_index, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_out_ovf", out_ovf, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", in_ready, 1);
        push(4096, 0, 1, 0, -1);
        send(16'd4096, 4'd0);
        wait_done();
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
